// File: rtl/register_file_sb_if.sv
// Bundle of the register file's writeback, read, issue and scoreboard signals.
// Ports: master drives i_* (decode/writeback side) and observes o_*; slave is the register file.
// Latency: reads, pending and WAW are combinational; pending count is registered. No backpressure.
interface register_file_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2
) ();
  // writeback
  logic                             i_we;
  logic [ADDR_WIDTH-1:0]            i_wr_address;
  logic [DATA_WIDTH-1:0]            i_wr_data;
  // read ports, packed with port k at [k*WIDTH +: WIDTH]
  logic [NUM_RD*ADDR_WIDTH-1:0]     i_rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]     o_rd_data;
  logic [NUM_RD-1:0]                o_rd_pending;
  // issue / scoreboard
  logic                             i_issue_valid;
  logic [ADDR_WIDTH-1:0]            i_issue_rd;
  logic                             o_issue_waw;
  logic                             i_flush;
  logic [ADDR_WIDTH:0]              o_pending_count;

  modport master (
    output i_we, i_wr_address, i_wr_data, i_rd_addr,
           i_issue_valid, i_issue_rd, i_flush,
    input  o_rd_data, o_rd_pending, o_issue_waw, o_pending_count
  );

  modport slave (
    input  i_we, i_wr_address, i_wr_data, i_rd_addr,
           i_issue_valid, i_issue_rd, i_flush,
    output o_rd_data, o_rd_pending, o_issue_waw, o_pending_count
  );
endinterface

// File: rtl/register_file_sb.sv
// Integer register file with NUM_RD read ports, optional writeback bypass and per-register pending scoreboard.
// Ports: clk, rst (async active-high), rf (slave modport: writeback, packed reads, issue, flush, pending count).
// Latency: reads/pending/WAW combinational (0 cycles); pending count registered (1 cycle). No backpressure: hazards are reported, the caller stalls.
module register_file_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic               clk,
  input  logic               rst,
  register_file_sb_if.slave  rf
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;

  logic [ADDR_WIDTH-1:0]        rd_addr [NUM_RD];
  logic                         byp_hit [NUM_RD];
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
  logic [NUM_RD-1:0]            rd_pend_c;

  // Next-state: data write, scoreboard update and the popcount of the new scoreboard.
  always_comb begin
    regs_d = regs_q;
    if (rf.i_we && (rf.i_wr_address != '0)) begin
      regs_d[rf.i_wr_address] = rf.i_wr_data;
    end

    pend_d = pend_q;
    if (rf.i_flush) begin
      // Flush kills every outstanding producer, including one issuing this cycle.
      pend_d = '0;
    end else begin
      // Clear on writeback first so a same-cycle issue to the same register
      // wins: the newer producer is still outstanding.
      if (rf.i_we) begin
        pend_d[rf.i_wr_address] = 1'b0;
      end
      if (rf.i_issue_valid) begin
        pend_d[rf.i_issue_rd] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;

    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign rd_addr[g] = rf.i_rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign byp_hit[g] = (BYPASS != 0) && rf.i_we && (rf.i_wr_address == rd_addr[g]);
  end

  // Read mux. x0 short-circuits to zero / not pending, which also covers a
  // bypassed write to x0.
  always_comb begin
    rd_data_c = '0;
    rd_pend_c = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k] != '0) begin
        if (byp_hit[k]) begin
          rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = rf.i_wr_data;
        end else begin
          rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[k]];
        end
        rd_pend_c[k] = pend_q[rd_addr[k]] & ~byp_hit[k];
      end
    end
  end

  assign rf.o_rd_data       = rd_data_c;
  assign rf.o_rd_pending    = rd_pend_c;
  // pend_q[0] is always 0, so issue to x0 never reports WAW.
  assign rf.o_issue_waw     = rf.i_issue_valid && pend_q[rf.i_issue_rd];
  assign rf.o_pending_count = count_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two instances (BYPASS=0/NUM_RD=2 and BYPASS=1/NUM_RD=4) share one stimulus stream.
// Ports: none; drives both interfaces, scoreboard queue of expected outputs checked by a negedge monitor.
// Latency: inputs driven at posedge+1, outputs checked at the following negedge.
module tb_register_file_sb;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [19:0]   ra = '0;
  logic          iv = 1'b0;
  logic [AW-1:0] ird = '0;
  logic          flush = 1'b0;

  register_file_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(2)) bus0 ();
  register_file_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(4)) bus1 ();

  assign bus0.i_we = we;            assign bus1.i_we = we;
  assign bus0.i_wr_address = wa;    assign bus1.i_wr_address = wa;
  assign bus0.i_wr_data = wd;       assign bus1.i_wr_data = wd;
  assign bus0.i_rd_addr = ra[9:0];  assign bus1.i_rd_addr = ra;
  assign bus0.i_issue_valid = iv;   assign bus1.i_issue_valid = iv;
  assign bus0.i_issue_rd = ird;     assign bus1.i_issue_rd = ird;
  assign bus0.i_flush = flush;      assign bus1.i_flush = flush;

  register_file_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(2), .BYPASS(0))
    dut0 (.clk(clk), .rst(rst), .rf(bus0));
  register_file_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(4), .BYPASS(1))
    dut1 (.clk(clk), .rst(rst), .rf(bus1));

  typedef struct packed {
    logic [63:0]  d0;
    logic [1:0]   p0;
    logic [127:0] d1;
    logic [3:0]   p1;
    logic         waw;
    logic [5:0]   cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural register values and the set of registers
  // with an outstanding producer.
  logic [DW-1:0] m_regs [32];
  bit            m_pend [32];

  function automatic logic [19:0] pack4(int a0, int a1, int a2, int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [DW-1:0] m_read(int a, bit byp);
    if (a == 0) return '0;
    if (byp && we && int'(wa) == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_pnd(int a, bit byp);
    if (a == 0) return 1'b0;
    return m_pend[a] && !(byp && we && int'(wa) == a);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int a;
    int n;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      a = int'(ra[k*5 +: 5]);
      e.d1[k*32 +: 32] = m_read(a, 1'b1);
      e.p1[k] = m_pnd(a, 1'b1);
      if (k < 2) begin
        e.d0[k*32 +: 32] = m_read(a, 1'b0);
        e.p0[k] = m_pnd(a, 1'b0);
      end
    end
    e.waw = iv && (ird != 0) && m_pend[ird];
    n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_pend[r]);
    e.cnt = 6'(n);
    return e;
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endfunction

  // Clock-edge effect of the current inputs on the model.
  function automatic void m_edge();
    if (we && wa != 0) m_regs[wa] = wd;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else begin
      if (we) m_pend[wa] = 1'b0;
      if (iv && ird != 0) m_pend[ird] = 1'b1;
    end
  endfunction

  task automatic step(input bit we_i, input int wa_i, input logic [DW-1:0] wd_i,
                      input logic [19:0] ra_i, input bit iv_i, input int ird_i,
                      input bit fl_i);
    @(posedge clk);
    #1;
    rst = 1'b0; we = we_i; wa = AW'(wa_i); wd = wd_i; ra = ra_i;
    iv = iv_i; ird = AW'(ird_i); flush = fl_i;
    q.push_back(predict());
    m_edge();
  endtask

  // Reset raised between edges; outputs must be clear before the next edge.
  task automatic reset_mid(input logic [19:0] ra_i);
    @(posedge clk);
    #1;
    rst = 1'b1; we = 1'b0; iv = 1'b0; flush = 1'b0; ra = ra_i;
    m_reset();
    q.push_back(predict());
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data_nobyp",  128'(bus0.o_rd_data),       128'(e.d0));
        chk("rd_pend_nobyp",  128'(bus0.o_rd_pending),    128'(e.p0));
        chk("waw_nobyp",      128'(bus0.o_issue_waw),     128'(e.waw));
        chk("count_nobyp",    128'(bus0.o_pending_count), 128'(e.cnt));
        chk("rd_data_byp",    bus1.o_rd_data,             e.d1);
        chk("rd_pend_byp",    128'(bus1.o_rd_pending),    128'(e.p1));
        chk("waw_byp",        128'(bus1.o_issue_waw),     128'(e.waw));
        chk("count_byp",      128'(bus1.o_pending_count), 128'(e.cnt));
      end
    end
  end

  initial begin : driver
    m_reset();
    reset_mid(pack4(1, 2, 3, 4));

    // Fill r_i = i+1 (write to x0 discarded), reading the target as it is written.
    for (int i = 0; i < 32; i++) step(1, i, DW'(i + 1), pack4(i, (i + 31) % 32, i, 0), 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, '0, pack4(i, (i + 1) % 32, (i + 1) % 32, i), 0, 0, 0);

    // Issue r5, observe pending, resolve by writeback (bypass clears same cycle).
    step(0, 0, '0, pack4(5, 5, 5, 0), 1, 5, 0);
    step(0, 0, '0, pack4(5, 0, 5, 5), 0, 0, 0);
    step(1, 5, 32'hDEADBEEF, pack4(5, 5, 5, 6), 0, 0, 0);
    step(0, 0, '0, pack4(5, 5, 5, 5), 0, 0, 0);

    // Same-cycle issue and writeback to r7: issue wins, then WAW on re-issue.
    step(1, 7, 32'h55, pack4(7, 7, 7, 7), 1, 7, 0);
    step(0, 0, '0, pack4(7, 7, 7, 0), 1, 7, 0);

    // Build up pending then flush alongside an issue to r4.
    step(0, 0, '0, pack4(1, 2, 3, 4), 1, 1, 0);
    step(0, 0, '0, pack4(1, 2, 3, 4), 1, 2, 0);
    step(0, 0, '0, pack4(1, 2, 3, 4), 1, 3, 0);
    step(1, 2, 32'hA5A5_0002, pack4(1, 2, 3, 4), 1, 4, 1);
    step(0, 0, '0, pack4(1, 2, 3, 4), 0, 0, 0);

    // x0: issue and write are both no-ops.
    step(1, 0, 32'hFFFFFFFF, pack4(0, 0, 0, 0), 1, 0, 0);
    step(0, 0, '0, pack4(0, 0, 0, 0), 1, 0, 0);

    // All ports on one register, then async reset mid-cycle with state present.
    step(1, 9, 32'h1234, pack4(9, 9, 9, 9), 1, 10, 0);
    step(0, 0, '0, pack4(9, 9, 9, 9), 0, 0, 0);
    reset_mid(pack4(9, 9, 10, 5));
    step(0, 0, '0, pack4(9, 9, 10, 5), 0, 0, 0);

    // Random traffic on a small address pool to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_mid(pack4($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7)));
      end else begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom(),
             pack4($urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 31)),
             $urandom_range(0, 9) < 4, $urandom_range(0, 7),
             $urandom_range(0, 19) == 0);
      end
    end

    step(0, 0, '0, pack4(1, 2, 3, 4), 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the RV32I integer register file: configurable read-port count, optional write-to-read bypass, and a per-register scoreboard (pending bits) for the pipelined core.
- Sits between decode (read/issue) and writeback. Hazard logic uses the pending outputs to stall on RAW and WAW.
- Register x0 is hardwired to zero and is never pending.

Parameters:
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_RD, 2, number of read ports; legal range 1..4.
- BYPASS, 1, when 1 the same-cycle writeback value is forwarded to matching read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- i_we  input  1  writeback write enable.
- i_wr_address  input  ADDR_WIDTH  writeback destination register.
- i_wr_data  input  DATA_WIDTH  writeback data.
- i_rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_rd_data  output  NUM_RD*DATA_WIDTH  packed read data, same packing.
- o_rd_pending  output  NUM_RD  port k's source register awaits writeback.
- i_issue_valid  input  1  an instruction with destination i_issue_rd is issued.
- i_issue_rd  input  ADDR_WIDTH  destination register of the issuing instruction.
- o_issue_waw  output  1  i_issue_valid and i_issue_rd is already pending (WAW).
- i_flush  input  1  pipeline flush; clears all pending bits.
- o_pending_count  output  ADDR_WIDTH+1  registered count of pending registers.

Behaviour:
- Reset (async, rst=1):
  - All registers clear to 0, all pending bits clear to 0, o_pending_count = 0.
  - Combinational outputs then read 0 / not pending.
- Write:
  - On posedge, if i_we and i_wr_address != 0, then regs[i_wr_address] <= i_wr_data.
  - Writes to address 0 are discarded.
- Read (combinational, zero latency):
  - If addr_k == 0, o_rd_data[k] = 0.
  - Else if BYPASS and i_we and i_wr_address == addr_k, o_rd_data[k] = i_wr_data.
  - Else o_rd_data[k] = regs[addr_k].
  - With BYPASS=0 the new value is visible from the cycle after the write edge.
- Pending bit update, per register r != 0, on posedge, in priority order:
  1. i_flush: pend[r] <= 0 for every r. A simultaneous issue is ignored. A simultaneous write still updates data.
  2. i_issue_valid and i_issue_rd == r: pend[r] <= 1. Issue wins over a same-cycle writeback to the same r (the newer producer is outstanding).
  3. i_we and i_wr_address == r: pend[r] <= 0.
  4. Otherwise hold.
- pend[0] is constant 0. Issue to x0 has no effect and o_issue_waw = 0.
- o_rd_pending[k] = pend[addr_k] & ~(BYPASS & i_we & (i_wr_address == addr_k)).
  - With bypass, the resolving writeback clears the hazard in the same cycle.
  - addr_k == 0 always gives 0.
- o_issue_waw = i_issue_valid & (i_issue_rd != 0) & pend[i_issue_rd]. Combinational, not suppressed by i_we.
- o_pending_count:
  - Registered; equals the popcount of pend after each edge.
  - Maximum is 2**ADDR_WIDTH - 1 (x0 excluded), so no overflow.
  - Flush returns it to 0 on the next edge.
- Multiple read ports may address the same register; each returns identical data and pending status.
- Reset asserted mid-operation clears state immediately, independent of clk. First update occurs on the first posedge after rst deasserts.

Test Plan:
- Reset, then write r=i data=i+1 for i=0..31. Read pairs (i, i+1) with BYPASS=0 -> addr 0 reads 0; addr i≠0 reads i+1; o_pending_count = 0.
- Issue rd=5. Next cycle read port 0 addr 5 -> o_rd_pending[0]=1, count=1. Writeback r5=0xDEADBEEF with BYPASS=1 -> same cycle o_rd_data[0]=0xDEADBEEF, o_rd_pending[0]=0; after edge count=0.
- Same cycle issue rd=7 and writeback r7=0x55 -> after edge r7=0x55, pend[7]=1, count=1. A following issue rd=7 -> o_issue_waw=1.
- Issue rd=1,2,3 on successive cycles (count 1,2,3). Assert i_flush together with issue rd=4 -> after edge count=0, none pending, r4 not pending.
- Issue rd=0 and write r0=0xFFFFFFFF -> o_issue_waw=0, count unchanged, all ports addressing 0 read 0.
- NUM_RD=4, all ports addr 9 after write 0x1234 -> all four o_rd_data=0x1234. Assert rst asynchronously mid-clock -> all outputs 0 before the next edge.
